// File: rtl/uart_tx_scheduler.sv
// Avalon-MM master in front of uart_core: round-robin TX of two byte streams with
// status polling, and IRQ-driven RX forwarding. Optional counters: UART_SCHED_STATS_EN.
module uart_tx_scheduler #(
  parameter logic [3:0]  ADDR_TXDATA = 4'h0,
  parameter logic [3:0]  ADDR_STATUS = 4'h1,
  parameter logic [3:0]  ADDR_RXDATA = 4'h2,
  parameter int unsigned POLL_MAX    = 1024
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic [1:0] req_valid_i,
  input  logic [7:0] req_data0_i,
  input  logic [7:0] req_data1_i,
  output logic [1:0] req_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       timeout_o,
  output logic [3:0] avm_address_o,
  output logic       avm_read_o,
  output logic       avm_write_o,
  output logic [7:0] avm_writedata_o,
  input  logic [7:0] avm_readdata_i,
  input  logic       irq_i
`ifdef UART_SCHED_STATS_EN
  ,
  output logic [15:0] tx_cnt0_o,
  output logic [15:0] tx_cnt1_o,
  output logic [15:0] rx_cnt_o,
  output logic [15:0] drop_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RX_RD   = 3'd1;
  localparam logic [2:0] RX_WAIT = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] TX_WR   = 3'd5;
  localparam logic [2:0] GAP     = 3'd6;

  logic [2:0]    state, state_nx;
  logic          last_grant;
  logic [7:0]    byte_q;
  logic [PW-1:0] poll_cnt;
  logic          resume_q;

  logic          grant_en;
  logic          grant_idx;
  logic          timeout_now;
  logic          preempt_now;

  // Prefer the requester that was not served last; fall back to the other one.
  assign grant_idx = req_valid_i[~last_grant] ? ~last_grant : last_grant;

  always_comb begin
    state_nx    = state;
    grant_en    = 1'b0;
    timeout_now = 1'b0;
    preempt_now = 1'b0;
    case (state)
      IDLE: begin
        if (irq_i) begin
          state_nx = RX_RD;
        end else if (|req_valid_i) begin
          grant_en = 1'b1;
          state_nx = ST_RD;
        end
      end
      RX_RD:   state_nx = RX_WAIT;
      RX_WAIT: state_nx = GAP;
      ST_RD:   state_nx = ST_WAIT;
      ST_WAIT: begin
        if (avm_readdata_i[0]) begin
          state_nx = TX_WR;
        end else if (poll_cnt == POLL_LAST) begin
          timeout_now = 1'b1;
          state_nx    = GAP;
        end else if (irq_i) begin
          preempt_now = 1'b1;
          state_nx    = RX_RD;
        end else begin
          state_nx = ST_RD;
        end
      end
      TX_WR:   state_nx = GAP;
      GAP:     state_nx = resume_q ? ST_RD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake: a byte is captured on the clock edge that ends the granting IDLE
  // cycle; req_ready_o[g] pulses in the following cycle and the requester may
  // present its next byte after that pulse. Bus strobes are decoded from the
  // next state so each strobe is high for exactly the first cycle of its state.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      byte_q          <= 8'h00;
      poll_cnt        <= '0;
      resume_q        <= 1'b0;
      req_ready_o     <= 2'b00;
      rx_valid_o      <= 1'b0;
      rx_data_o       <= 8'h00;
      timeout_o       <= 1'b0;
      avm_address_o   <= ADDR_STATUS;
      avm_read_o      <= 1'b0;
      avm_write_o     <= 1'b0;
      avm_writedata_o <= 8'h00;
    end else begin
      state       <= state_nx;
      avm_read_o  <= (state_nx == RX_RD) || (state_nx == ST_RD);
      avm_write_o <= (state_nx == TX_WR);
      req_ready_o <= grant_en ? (2'b01 << grant_idx) : 2'b00;
      rx_valid_o  <= (state == RX_WAIT);
      timeout_o   <= timeout_now;

      if (state_nx == RX_RD) begin
        avm_address_o <= ADDR_RXDATA;
      end else if (state_nx == ST_RD) begin
        avm_address_o <= ADDR_STATUS;
      end else if (state_nx == TX_WR) begin
        avm_address_o   <= ADDR_TXDATA;
        avm_writedata_o <= byte_q;
      end

      if (state == RX_WAIT) begin
        rx_data_o <= avm_readdata_i;
      end

      if (grant_en) begin
        byte_q     <= grant_idx ? req_data1_i : req_data0_i;
        last_grant <= grant_idx;
        poll_cnt   <= '0;
      end else if ((state == ST_RD) && (poll_cnt != POLL_LAST)) begin
        poll_cnt <= poll_cnt + PW'(1);
      end

      // Poll count survives an RX pre-emption; only a new grant restarts it.
      if (preempt_now) begin
        resume_q <= 1'b1;
      end else if (state == GAP) begin
        resume_q <= 1'b0;
      end
    end
  end

`ifdef UART_SCHED_STATS_EN
  logic owner_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      owner_q    <= 1'b0;
      tx_cnt0_o  <= 16'h0000;
      tx_cnt1_o  <= 16'h0000;
      rx_cnt_o   <= 16'h0000;
      drop_cnt_o <= 16'h0000;
    end else begin
      if (grant_en) begin
        owner_q <= grant_idx;
      end
      if ((state == TX_WR) && !owner_q) begin
        tx_cnt0_o <= tx_cnt0_o + 16'h0001;
      end
      if ((state == TX_WR) && owner_q) begin
        tx_cnt1_o <= tx_cnt1_o + 16'h0001;
      end
      if (state == RX_WAIT) begin
        rx_cnt_o <= rx_cnt_o + 16'h0001;
      end
      if (timeout_now) begin
        drop_cnt_o <= drop_cnt_o + 16'h0001;
      end
    end
  end
`endif

endmodule
